// File: rtl/sio_l2b_pkg.sv
// Shared field positions, packet record and FSM states for the L2-bank return receiver.
package sio_l2b_pkg;

   localparam int OPES_MSB      = 23;
   localparam int CBA_MSB       = 19;
   localparam int TAG_MSB       = 15;
   localparam int OPES_DATA_BIT = 3;
   localparam int BEAT_W        = 32;
   localparam int PAYLOAD_W     = 512;

   typedef struct packed {
      logic [15:0]          tag;
      logic [3:0]           cba;
      logic [3:0]           opes;
      logic                 has_data;
      logic                 ue;
      logic                 pe;
      logic [PAYLOAD_W-1:0] data;
   } pkt_t;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_e;

   // Even parity per 16-bit half; 1 means the beat arrived corrupted.
   function automatic logic beat_par_err(input logic [BEAT_W-1:0] d, input logic [1:0] p);
      return ((^d[31:16]) != p[1]) || ((^d[15:0]) != p[0]);
   endfunction

endpackage

// File: rtl/sio_l2b_pkt_fifo.sv
// Generic DEPTH-entry packet FIFO; a pop in the same cycle frees a slot for a push.
module sio_l2b_pkt_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign full_o  = (cnt_q == (AW+1)'(DEPTH)) && !do_pop;
   assign do_push = push_i && !full_o;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/sio_l2b_rsp_rcv.sv
// Per-bank L2->SIO return receiver: frames header/data beats into packets, queues them, returns credits.
// Parity checking is compiled in only when SIO_L2B_PAR_CHK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a header beat (header-only packets push immediately)
// DATA  | collecting BEATS payload beats of a read response
module sio_l2b_rsp_rcv
   import sio_l2b_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int BEATS   = 16,
   parameter int BANK_ID = 0
) (
   input  logic                 iol2clk,
   input  logic                 rst_l,
   input  logic                 l2b_sio_ctag_vld,
   input  logic [BEAT_W-1:0]    l2b_sio_data,
   input  logic [1:0]           l2b_sio_parity,
   input  logic                 l2b_sio_ue_err,
   output logic                 sio_l2b_credit,
   output logic                 rsp_vld,
   input  logic                 rsp_rdy,
   output logic [15:0]          rsp_tag,
   output logic [3:0]           rsp_cba,
   output logic [3:0]           rsp_opes,
   output logic                 rsp_has_data,
   output logic [PAYLOAD_W-1:0] rsp_data,
   output logic                 rsp_ue,
   output logic                 rsp_pe,
   output logic                 err_ovf,
   output logic                 err_proto,
   output logic [2:0]           err_bank
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   pkt_t          pkt_q, pkt_d;
   pkt_t          hdr_pkt, push_pkt, head, head_v;
   logic          drop_q, drop_d;
   logic          ovf_q, ovf_d;
   logic          proto_q, proto_d;
   logic          credit_q;
   logic          push, pop, fifo_full, fifo_empty;
   logic          pe_beat;

`ifdef SIO_L2B_PAR_CHK_EN
   assign pe_beat = beat_par_err(l2b_sio_data, l2b_sio_parity);
`else
   logic par_unused;
   assign par_unused = ^l2b_sio_parity;
   assign pe_beat    = 1'b0;
`endif

   always_comb begin
      hdr_pkt          = '0;
      hdr_pkt.opes     = l2b_sio_data[OPES_MSB -: 4];
      hdr_pkt.cba      = l2b_sio_data[CBA_MSB -: 4];
      hdr_pkt.tag      = l2b_sio_data[TAG_MSB -: 16];
      hdr_pkt.has_data = l2b_sio_data[OPES_MSB - 3 + OPES_DATA_BIT];
      hdr_pkt.ue       = l2b_sio_ue_err;
      hdr_pkt.pe       = pe_beat;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pkt_d    = pkt_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      proto_d  = proto_q;
      push     = 1'b0;
      push_pkt = pkt_q;
      if (l2b_sio_ctag_vld) begin
         // A header mid-payload abandons the partial packet and restarts framing.
         if (state_q == DATA) proto_d = 1'b1;
         if (fifo_full)       ovf_d   = 1'b1;
         cnt_d = '0;
         if (hdr_pkt.has_data) begin
            state_d = DATA;
            pkt_d   = hdr_pkt;
            drop_d  = fifo_full;
         end else begin
            state_d  = IDLE;
            push     = !fifo_full;
            push_pkt = hdr_pkt;
         end
      end else if (state_q == DATA) begin
         pkt_d.data = {pkt_q.data[PAYLOAD_W-BEAT_W-1:0], l2b_sio_data};
         pkt_d.ue   = pkt_q.ue | l2b_sio_ue_err;
         pkt_d.pe   = pkt_q.pe | pe_beat;
         cnt_d      = cnt_q + 1'b1;
         if (cnt_q == CW'(BEATS - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            push     = !drop_q;
            push_pkt = pkt_d;
         end
      end
   end

   always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pkt_q    <= '0;
         drop_q   <= 1'b0;
         ovf_q    <= 1'b0;
         proto_q  <= 1'b0;
         credit_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pkt_q    <= pkt_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
         proto_q  <= proto_d;
         credit_q <= pop;
      end
   end

   sio_l2b_pkt_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(pkt_t))
   ) u_fifo (
      .clk_i   (iol2clk),
      .rst_ni  (rst_l),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (push_pkt),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign rsp_vld = !fifo_empty;
   assign pop     = rsp_vld && rsp_rdy;

   // Unwritten FIFO slots never reach the outputs.
   assign head_v = rsp_vld ? head : '0;

   assign rsp_tag        = head_v.tag;
   assign rsp_cba        = head_v.cba;
   assign rsp_opes       = head_v.opes;
   assign rsp_has_data   = head_v.has_data;
   assign rsp_data       = head_v.data;
   assign rsp_ue         = head_v.ue;
   assign rsp_pe         = head_v.pe;
   assign sio_l2b_credit = credit_q;
   assign err_ovf        = ovf_q;
   assign err_proto      = proto_q;
   assign err_bank       = 3'(BANK_ID);

endmodule

// File: tb/tb_sio_l2b_rsp_rcv.sv
// Bench for sio_l2b_rsp_rcv: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_sio_l2b_rsp_rcv;

   localparam int DEPTH   = 4;
   localparam int BEATS   = 16;
   localparam int BANK_ID = 5;
   localparam int HW      = 539;
`ifdef SIO_L2B_PAR_CHK_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic         iol2clk = 1'b0;
   logic         rst_l = 1'b0;
   logic         ctag_vld = 1'b0;
   logic [31:0]  l2b_data = '0;
   logic [1:0]   parity = '0;
   logic         ue_err = 1'b0;
   logic         rsp_rdy = 1'b0;
   logic         sio_l2b_credit, rsp_vld, rsp_has_data, rsp_ue, rsp_pe, err_ovf, err_proto;
   logic [15:0]  rsp_tag;
   logic [3:0]   rsp_cba, rsp_opes;
   logic [511:0] rsp_data;
   logic [2:0]   err_bank;

   always #5 iol2clk = ~iol2clk;

   sio_l2b_rsp_rcv #(.DEPTH(DEPTH), .BEATS(BEATS), .BANK_ID(BANK_ID)) dut (
      .iol2clk          (iol2clk),
      .rst_l            (rst_l),
      .l2b_sio_ctag_vld (ctag_vld),
      .l2b_sio_data     (l2b_data),
      .l2b_sio_parity   (parity),
      .l2b_sio_ue_err   (ue_err),
      .sio_l2b_credit   (sio_l2b_credit),
      .rsp_vld          (rsp_vld),
      .rsp_rdy          (rsp_rdy),
      .rsp_tag          (rsp_tag),
      .rsp_cba          (rsp_cba),
      .rsp_opes         (rsp_opes),
      .rsp_has_data     (rsp_has_data),
      .rsp_data         (rsp_data),
      .rsp_ue           (rsp_ue),
      .rsp_pe           (rsp_pe),
      .err_ovf          (err_ovf),
      .err_proto        (err_proto),
      .err_bank         (err_bank)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic chk_head(input logic [HW-1:0] act, input logic [HW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL head actual=%0h required=%0h", act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0]  tag;
      logic [3:0]   cba;
      logic [3:0]   opes;
      logic         has_data;
      logic         ue;
      logic         pe;
      logic [511:0] data;
   } pkt_s;

   pkt_s        mq[$];
   pkt_s        m_cur;
   logic [31:0] m_beats[$];
   bit          m_coll, m_drop, m_ovf, m_proto, m_credit;

   function automatic logic par_bad(input logic [31:0] d, input logic [1:0] p);
      if (!PAR_ON) return 1'b0;
      return ((($countones(d[31:16]) % 2) != int'(p[1])) || (($countones(d[15:0]) % 2) != int'(p[0])));
   endfunction

   always @(posedge iol2clk or negedge rst_l) begin
      bit   pop, full, pushing;
      pkt_s np;
      if (!rst_l) begin
         mq.delete();
         m_beats.delete();
         m_coll = 0; m_drop = 0; m_ovf = 0; m_proto = 0; m_credit = 0;
      end else begin
         pop     = (mq.size() != 0) && rsp_rdy;
         full    = (mq.size() == DEPTH) && !pop;
         pushing = 0;
         if (ctag_vld) begin
            if (m_coll) m_proto = 1;
            if (full) m_ovf = 1;
            m_coll         = 0;
            m_cur.opes     = l2b_data[23:20];
            m_cur.cba      = l2b_data[19:16];
            m_cur.tag      = l2b_data[15:0];
            m_cur.has_data = l2b_data[23];
            m_cur.ue       = ue_err;
            m_cur.pe       = par_bad(l2b_data, parity);
            m_cur.data     = '0;
            if (m_cur.has_data) begin
               m_coll = 1;
               m_drop = full;
               m_beats.delete();
            end else if (!full) begin
               pushing = 1;
               np      = m_cur;
            end
         end else if (m_coll) begin
            m_beats.push_back(l2b_data);
            m_cur.ue = m_cur.ue | ue_err;
            m_cur.pe = m_cur.pe | par_bad(l2b_data, parity);
            if (m_beats.size() == BEATS) begin
               m_coll = 0;
               for (int i = 0; i < BEATS; i++) m_cur.data[511-32*i -: 32] = m_beats[i];
               if (!m_drop) begin
                  pushing = 1;
                  np      = m_cur;
               end
            end
         end
         m_credit = pop;
         if (pop) void'(mq.pop_front());
         if (pushing) mq.push_back(np);
      end
   end

   function automatic logic [HW-1:0] pack(input logic [15:0] t, input logic [3:0] c, input logic [3:0] o,
                                          input logic hd, input logic u, input logic p, input logic [511:0] d);
      return {t, c, o, hd, u, p, hd ? d : 512'd0};
   endfunction

   always @(negedge iol2clk) begin
      if (!rst_l) begin
         chk("rst_vld", 64'(rsp_vld), 64'd0);
         chk("rst_credit", 64'(sio_l2b_credit), 64'd0);
         chk("rst_errs", 64'({err_ovf, err_proto}), 64'd0);
      end else begin
         chk("vld", 64'(rsp_vld), 64'(mq.size() != 0));
         if (mq.size() != 0)
            chk_head(pack(rsp_tag, rsp_cba, rsp_opes, rsp_has_data, rsp_ue, rsp_pe, rsp_data),
                     pack(mq[0].tag, mq[0].cba, mq[0].opes, mq[0].has_data, mq[0].ue, mq[0].pe, mq[0].data));
         chk("credit", 64'(sio_l2b_credit), 64'(m_credit));
         chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
         chk("err_proto", 64'(err_proto), 64'(m_proto));
         chk("err_bank", 64'(err_bank), 64'(BANK_ID));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge iol2clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input bit ue, input logic [1:0] pflip);
      ctag_vld = v;
      l2b_data = d;
      ue_err   = ue;
      parity   = {^d[31:16], ^d[15:0]} ^ pflip;
      tick();
   endtask

   task automatic idle_cycles(input int n);
      ctag_vld = 0; l2b_data = '0; ue_err = 0; parity = '0;
      repeat (n) tick();
   endtask

   function automatic logic [31:0] hdr(input logic [3:0] opes, input logic [3:0] cba, input logic [15:0] tag);
      return {8'h00, opes, cba, tag};
   endfunction

   initial begin
      int          ncred, ngot, beats_left, bias;
      logic [63:0] got;
      bit          v;
      logic [31:0] d;

      rst_l = 0;
      repeat (3) @(posedge iol2clk);
      #1;
      chk("reset_vld", 64'(rsp_vld), 64'd0);
      chk("reset_credit", 64'(sio_l2b_credit), 64'd0);
      chk("reset_errs", 64'({err_ovf, err_proto}), 64'd0);
      chk("reset_tag", 64'(rsp_tag), 64'd0);
      rst_l = 1;
      idle_cycles(2);

      // read return
      rsp_rdy = 1;
      drive(1, hdr(4'h8, 4'h3, 16'h1A2B), 0, 2'b00);
      for (int i = 0; i < BEATS; i++) begin
         if (i == BEATS - 1) chk("t1_not_early", 64'(rsp_vld), 64'd0);
         drive(0, 32'(i), 0, 2'b00);
      end
      chk("t1_vld", 64'(rsp_vld), 64'd1);
      chk("t1_beat0", 64'(rsp_data[511:480]), 64'd0);
      chk("t1_beat15", 64'(rsp_data[31:0]), 64'hF);
      chk("t1_has_data", 64'(rsp_has_data), 64'd1);
      chk("t1_tag", 64'(rsp_tag), 64'h1A2B);
      chk("t1_cba", 64'(rsp_cba), 64'h3);
      idle_cycles(1);
      chk("t1_credit", 64'(sio_l2b_credit), 64'd1);
      chk("t1_drained", 64'(rsp_vld), 64'd0);
      idle_cycles(1);
      chk("t1_credit_once", 64'(sio_l2b_credit), 64'd0);

      // header-only
      drive(1, hdr(4'h2, 4'h0, 16'h0007), 0, 2'b00);
      chk("t2_vld", 64'(rsp_vld), 64'd1);
      chk("t2_has_data", 64'(rsp_has_data), 64'd0);
      chk("t2_tag", 64'(rsp_tag), 64'h0007);
      idle_cycles(2);

      // overflow
      rsp_rdy = 0;
      for (int t = 1; t <= 5; t++) drive(1, hdr(4'h2, 4'h0, 16'(t)), 0, 2'b00);
      chk("t3_ovf", 64'(err_ovf), 64'd1);
      idle_cycles(1);
      rsp_rdy = 1;
      ncred = 0; ngot = 0; got = '0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_vld) begin
            got = {got[47:0], rsp_tag};
            ngot++;
         end
         tick();
         if (sio_l2b_credit) ncred++;
      end
      chk("t3_ncred", 64'(ncred), 64'd4);
      chk("t3_count", 64'(ngot), 64'd4);
      chk("t3_order", got, 64'h0001_0002_0003_0004);

      // protocol error
      rsp_rdy = 0;
      drive(1, hdr(4'h8, 4'h0, 16'h0011), 0, 2'b00);
      for (int i = 0; i < 5; i++) drive(0, $urandom(), 0, 2'b00);
      drive(1, hdr(4'h0, 4'h0, 16'h0022), 0, 2'b00);
      chk("t4_proto", 64'(err_proto), 64'd1);
      chk("t4_vld", 64'(rsp_vld), 64'd1);
      chk("t4_tag", 64'(rsp_tag), 64'h0022);
      rsp_rdy = 1;
      idle_cycles(1);
      chk("t4_only_one", 64'(rsp_vld), 64'd0);
      idle_cycles(1);

      // parity / ue
      rsp_rdy = 0;
      drive(1, hdr(4'h8, 4'h5, 16'h0033), 0, 2'b00);
      for (int i = 0; i < BEATS; i++)
         drive(0, $urandom(), (i == 3), (i == 7) ? 2'b01 : 2'b00);
      chk("t5_vld", 64'(rsp_vld), 64'd1);
      chk("t5_pe", 64'(rsp_pe), 64'(PAR_ON));
      chk("t5_ue", 64'(rsp_ue), 64'd1);
      rsp_rdy = 1;
      idle_cycles(2);

      // reset mid-payload
      rsp_rdy = 0;
      drive(1, hdr(4'h2, 4'h0, 16'h0041), 0, 2'b00);
      drive(1, hdr(4'h2, 4'h0, 16'h0042), 0, 2'b00);
      drive(1, hdr(4'h8, 4'h0, 16'h0043), 0, 2'b00);
      for (int i = 0; i < 8; i++) drive(0, 32'(i), 0, 2'b00);
      ctag_vld = 0; l2b_data = 32'd8;
      rst_l = 0;
      #1;
      chk("t6_vld_async", 64'(rsp_vld), 64'd0);
      idle_cycles(2);
      rst_l = 1;
      #1;
      chk("t6_errs_clear", 64'({err_ovf, err_proto}), 64'd0);
      rsp_rdy = 1;
      drive(1, hdr(4'h1, 4'h2, 16'h0055), 0, 2'b00);
      chk("t6_vld", 64'(rsp_vld), 64'd1);
      chk("t6_tag", 64'(rsp_tag), 64'h0055);
      chk("t6_has_data", 64'(rsp_has_data), 64'd0);
      idle_cycles(1);
      chk("t6_credit", 64'(sio_l2b_credit), 64'd1);
      idle_cycles(2);

      // random traffic
      beats_left = 0;
      bias = 3;
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) bias = $urandom_range(0, 4);
         rsp_rdy = ($urandom_range(0, 3) < bias);
         d = $urandom();
         if (beats_left > 0 && $urandom_range(0, 49) != 0) begin
            v = 0;
            beats_left--;
         end else if (beats_left > 0 || $urandom_range(0, 2) == 0) begin
            v = 1;
            beats_left = d[23] ? BEATS : 0;
         end else begin
            v = 0;
         end
         drive(v, d, ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      idle_cycles(BEATS + 2);
      rsp_rdy = 1;
      idle_cycles(12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
